// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - round-robin scheduler sharing one frame transmitter among NUM_REQ sources
// Optional WAIT_DONE abort watchdog with timeout_err output: define TX_SCHED_WATCHDOG_EN.

module tx_frame_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_en,
    input  logic                      tx_done,
    output logic                      busy,
`ifdef TX_SCHED_WATCHDOG_EN
    output logic                      timeout_err,
`endif
    output logic [15:0]               frame_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [IFG_W-1:0]   IFG_LOAD = IFG_W'(IFG_CYCLES);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, IFG} state_t;

    state_t            state, state_next;
    logic [PTR_W-1:0]  ptr, win, ptr_next;
    logic [DATA_W-1:0] sel_data;
    logic [IFG_W-1:0]  ifg_cnt;
    logic              wd_expire;
    logic              frame_end;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        int               idx;
        logic             found;
        logic [PTR_W-1:0] idx_p;
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        idx_p = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_p = PTR_W'(idx);
            if (!found && req[idx_p]) begin
                found = 1'b1;
                win   = idx_p;
            end
        end
    end

    assign ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PTR_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
        end
    end

`ifdef TX_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == WAIT_DONE) && !tx_done && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    assign frame_end = (state == WAIT_DONE) && (tx_done || wd_expire);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (|req) state_next = START;
            START:     state_next = WAIT_DONE;
            WAIT_DONE: if (frame_end) state_next = (IFG_CYCLES == 0) ? IDLE : IFG;
            IFG:       if (ifg_cnt <= IFG_W'(1)) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // tx_en is registered from START so the start pulse trails grant by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            grant       <= '0;
            tx_data     <= '0;
            tx_en       <= 1'b0;
            ack         <= '0;
            frame_cnt   <= '0;
            ifg_cnt     <= '0;
`ifdef TX_SCHED_WATCHDOG_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            tx_en <= (state == START);
            ack   <= '0;
`ifdef TX_SCHED_WATCHDOG_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= ONE_HOT0 << win;
                        tx_data <= sel_data;
                        ptr     <= ptr_next;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        ack       <= grant;
                        grant     <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                        ifg_cnt   <= IFG_LOAD;
                    end
`ifdef TX_SCHED_WATCHDOG_EN
                    else if (wd_expire) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        ifg_cnt     <= IFG_LOAD;
                    end
`endif
                end
                IFG: ifg_cnt <= ifg_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - self-checking bench for tx_frame_scheduler
// Reference model tracks frames as posedge timestamps (arbitration, completion, gap end).

module tb_tx_frame_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IFG  = 12;
    localparam int TMO  = 16;

    logic         clk, rst;
    logic [3:0]   req, ack, grant;
    logic [127:0] req_data;
    logic [31:0]  tx_data;
    logic         tx_en, tx_done, busy;
    logic [15:0]  frame_cnt;
`ifdef TX_SCHED_WATCHDOG_EN
    logic         timeout_err;
`endif

    tx_frame_scheduler #(
        .NUM_REQ(NREQ), .DATA_W(DW), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .grant(grant), .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
        .busy(busy),
`ifdef TX_SCHED_WATCHDOG_EN
        .timeout_err(timeout_err),
`endif
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   req;
        logic [127:0] data;
        int           delay;
        bit           drop;
        logic [3:0]   exp_grant;
        logic [31:0]  exp_data;
    } vec_t;

    vec_t tbl [7];

    int n_vec, n_bad;

    int          pk, free_at, arb_k, done_k, abort_k, m_w, last_w, m_ptr;
    bit          m_active;
    logic [31:0] m_data;
    logic [15:0] m_cnt;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pk = 0; free_at = 1; arb_k = -100; done_k = -100; abort_k = -100;
        m_w = 0; last_w = 0; m_ptr = 0; m_active = 0; m_data = '0; m_cnt = '0;
    endtask

    // Called once per rising edge with the inputs the DUT sampled at that edge.
    task automatic model_step();
        int  j;
        bit  found;
        pk++;
        if (m_active) begin
            if (pk >= arb_k + 2 && tx_done) begin
                m_active = 0; done_k = pk; last_w = m_w; m_cnt++;
                free_at = pk + IFG + 1;
            end
`ifdef TX_SCHED_WATCHDOG_EN
            else if (pk == arb_k + 1 + TMO) begin
                m_active = 0; abort_k = pk; free_at = pk + IFG + 1;
            end
`endif
        end else if (pk >= free_at && req != 4'b0) begin
            found = 0;
            for (int i = 0; i < NREQ; i++) begin
                j = (m_ptr + i) % NREQ;
                if (!found && req[j]) begin found = 1; m_w = j; end
            end
            m_active = 1; arb_k = pk;
            m_data = req_data[m_w*DW +: DW];
            m_ptr = (m_w + 1) % NREQ;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg, ea;
        eg = m_active ? (4'b0001 << m_w) : 4'b0000;
        ea = (pk == done_k) ? (4'b0001 << last_w) : 4'b0000;
        cmp("grant", 32'(grant), 32'(eg));
        cmp("tx_en", 32'(tx_en), 32'(m_active && pk == arb_k + 1));
        cmp("ack", 32'(ack), 32'(ea));
        cmp("busy", 32'(busy), 32'(m_active || pk < free_at - 1));
        cmp("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        cmp("tx_data", tx_data, m_data);
`ifdef TX_SCHED_WATCHDOG_EN
        cmp("timeout_err", 32'(timeout_err), 32'(pk == abort_k));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == 4'b0 && n < 64) begin tick(); n++; end
        if (grant == 4'b0) begin
            n_vec++; n_bad++;
            $display("FAIL wait_grant: grant 0 after %0d cycles, expected a grant", n);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 64) begin tick(); n++; end
        if (busy) begin
            n_vec++; n_bad++;
            $display("FAIL wait_idle: busy 1 after %0d cycles, expected 0", n);
        end
    endtask

    logic [127:0] pay;
    int           n, last_done;

    initial begin
        pay = {32'hC3C3C3C3, 32'h11223344, 32'hDEADBEEF, 32'hA0A0A0A0};
        tbl[0] = '{4'b0010, pay, 20, 1'b0, 4'b0010, 32'hDEADBEEF};
        tbl[1] = '{4'b0100, pay,  4, 1'b1, 4'b0100, 32'h11223344};
        tbl[2] = '{4'b1111, pay,  1, 1'b0, 4'b1000, 32'hC3C3C3C3};
        tbl[3] = '{4'b1111, pay,  2, 1'b0, 4'b0001, 32'hA0A0A0A0};
        tbl[4] = '{4'b0001, pay,  7, 1'b0, 4'b0001, 32'hA0A0A0A0};
        tbl[5] = '{4'b1010, pay,  3, 1'b0, 4'b0010, 32'hDEADBEEF};
        tbl[6] = '{4'b1010, pay,  5, 1'b0, 4'b1000, 32'hC3C3C3C3};

        n_vec = 0; n_bad = 0;
        rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp("rst_grant", 32'(grant), 0);
        cmp("rst_ack", 32'(ack), 0);
        cmp("rst_tx_en", 32'(tx_en), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_frame_cnt", 32'(frame_cnt), 0);
        cmp("rst_tx_data", tx_data, 0);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            req = tbl[t].req; req_data = tbl[t].data;
            wait_grant(n);
            cmp("tbl_grant", 32'(grant), 32'(tbl[t].exp_grant));
            cmp("tbl_data", tx_data, tbl[t].exp_data);
            if (tbl[t].drop) begin req = '0; req_data = '0; end
            tick();
            cmp("tbl_tx_en", 32'(tx_en), 1);
            repeat (tbl[t].delay - 1) tick();
            cmp("tbl_hold", tx_data, tbl[t].exp_data);
            tx_done = 1'b1; tick(); tx_done = 1'b0; req = '0;
            cmp("tbl_ack", 32'(ack), 32'(tbl[t].exp_grant));
            cmp("tbl_cnt", 32'(frame_cnt), t + 1);
            tick(); tx_done = 1'b1; tick(); tx_done = 1'b0;
            wait_idle(n);
            cmp("tbl_ifg", n + 2, IFG);
        end

        tx_done = 1'b1; tick(); tx_done = 1'b0;
        cmp("idle_spur_ack", 32'(ack), 0);
        cmp("idle_spur_cnt", 32'(frame_cnt), 7);
        cmp("idle_spur_busy", 32'(busy), 0);

        // All requesters held high: strict rotation and a fixed completion-to-grant gap.
        req = 4'hF; req_data = pay; last_done = 0;
        for (int f = 0; f < 8; f++) begin
            wait_grant(n);
            cmp("rr_grant", 32'(grant), 32'(4'b0001 << (f % 4)));
            if (f > 0) cmp("rr_gap", pk - last_done, IFG + 1);
            tick(); tick();
            tx_done = 1'b1; tick(); tx_done = 1'b0;
            last_done = pk;
        end
        req = '0;
        wait_idle(n);

        req = 4'b0010;
        wait_grant(n);
        cmp("pre_rst_grant", 32'(grant), 32'(4'b0010));
        tick(); tick(); tx_done = 1'b1; tick(); tx_done = 1'b0; req = '0;
        wait_idle(n);
        req = 4'b1100;
        wait_grant(n);
        cmp("mid_grant", 32'(grant), 32'(4'b0100));
        tick(); repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        cmp("async_grant", 32'(grant), 0);
        cmp("async_tx_en", 32'(tx_en), 0);
        cmp("async_ack", 32'(ack), 0);
        cmp("async_cnt", 32'(frame_cnt), 0);
        cmp("async_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_grant(n);
        cmp("post_rst_grant", 32'(grant), 32'(4'b0100));
        tick(); tick(); tx_done = 1'b1; tick(); tx_done = 1'b0;
        cmp("post_rst_ack", 32'(ack), 32'(4'b0100));
        cmp("post_rst_cnt", 32'(frame_cnt), 1);
        req = '0;
        wait_idle(n);

`ifdef TX_SCHED_WATCHDOG_EN
        req = 4'b0001;
        wait_grant(n);
        tick();
        n = 0;
        while (!timeout_err && n < 40) begin tick(); n++; end
        cmp("wd_delay", n, TMO);
        cmp("wd_ack", 32'(ack), 0);
        cmp("wd_grant", 32'(grant), 0);
        cmp("wd_cnt", 32'(frame_cnt), 1);
        wait_grant(n);
        cmp("wd_regrant", 32'(grant), 32'(4'b0001));
        tick(); tick(); tx_done = 1'b1; tick(); tx_done = 1'b0; req = '0;
        wait_idle(n);
`endif

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end else if (ack[i] && $urandom_range(0, 1) == 0) begin
                    req[i] = 1'b0;
                end else if (grant[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tx_done  = ($urandom_range(0, 5) == 0);
            tick();
        end
        req = '0; tx_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
Round-robin scheduler that shares the single Ethernet frame transmitter among NUM_REQ payload sources. It selects one requester and presents that requester's 32-bit payload on tx_data. It then pulses tx_en to start the transmitter and holds the payload stable until tx_done. Before accepting the next request it enforces a programmable inter-frame gap. It sits between the payload sources and the frame transmitter's data_in/tx_en/tx_done interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, payload width per requester
IFG_CYCLES, 12, idle clocks enforced after each tx_done (0 allowed)
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT_DONE (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester frame request; level, held until matching ack
req_data  in  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-hot, 1-cycle pulse: frame of requester i completed
grant  out  NUM_REQ  one-hot; high from selection until completion
tx_data  out  DATA_W  to transmitter data_in
tx_en  out  1  to transmitter; 1-cycle start pulse
tx_done  in  1  from transmitter; 1-cycle completion pulse
busy  out  1  high in every state except IDLE
frame_cnt  out  16  count of completed frames; wraps 0xFFFF->0

Behaviour:
- Reset (async, rst=1): state=IDLE; ack=0, grant=0, tx_data=0, tx_en=0, busy=0, frame_cnt=0; RR pointer=0. If reset arrives mid-frame, everything returns to these values immediately and the in-flight frame is not acked.
- States: IDLE, START, WAIT_DONE, IFG.
- IDLE: if |req, pick the first set bit searching upward from ptr with wrap.
  - Next cycle: grant<=onehot(w), tx_data<=req_data slice w (captured once), ptr<=(w+1) mod NUM_REQ, state->START.
  - If no req: stay in IDLE.
- START: tx_en=1 for exactly this one cycle; state->WAIT_DONE.
- WAIT_DONE: tx_en=0. grant and tx_data are held constant.
  - On tx_done=1: ack[w]<=1 for one cycle, grant<=0, frame_cnt<=frame_cnt+1.
  - Then state->IFG, or state->IDLE if IFG_CYCLES==0.
- IFG: remains exactly IFG_CYCLES cycles (down-counter loaded on entry, exit when it reaches 1), then ->IDLE. Requests are not sampled here.
- Latency: req rising in IDLE -> grant 1 cycle later -> tx_en 2 cycles later. tx_done -> ack next cycle -> IDLE after IFG_CYCLES more cycles.
- Requester rules:
  - req deasserted after grant is ignored; the frame completes and ack still pulses.
  - Changes to req_data after capture do not affect tx_data.
  - A requester may reassert req (or keep it high) in the cycle after its ack; it is then eligible in the next arbitration.
- tx_done outside WAIT_DONE is ignored.
- Fairness: with all req high, grants rotate 0,1,2,...,NUM_REQ-1,0,...
- tx_en and ack are never high in the same cycle. At most one grant bit is ever set.

Optional Feature:
Macro TX_SCHED_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in WAIT_DONE. If it reaches TIMEOUT_CYCLES without tx_done, the frame is aborted: grant<=0, no ack, frame_cnt unchanged, state->IFG.
  - Adds output port timeout_err (1 bit): 1-cycle pulse on abort, reset value 0.
  - The aborted requester keeps its req high and is retried under normal round-robin order.
- Not defined: no counter and no timeout_err port. WAIT_DONE waits indefinitely for tx_done.

Test Plan:
- Single request: req=4'b0010, req_data[63:32]=0xDEADBEEF; tx_done 20 cycles after tx_en.
  -> grant=0010 at cycle+1; tx_en at cycle+2; tx_data=0xDEADBEEF held until tx_done; ack=0010 the cycle after tx_done; frame_cnt=1; busy low 12 cycles later.
- All four req held high for 8 frames.
  -> grant order 0,1,2,3,0,1,2,3; exactly 12 idle cycles between each tx_done and the next grant.
- Requester 2 drops req and changes req_data to 0x0 right after grant (payload was 0x11223344).
  -> tx_data stays 0x11223344; ack[2] still pulses.
- rst asserted 5 cycles into WAIT_DONE.
  -> grant, tx_en and ack are 0 in the same cycle; frame_cnt=0; no ack pulses after release; with req still high, a new arbitration starts from ptr=0.
- Spurious tx_done while in IDLE and IFG.
  -> no ack pulse; frame_cnt unchanged; no state change.
- With TX_SCHED_WATCHDOG_EN and TIMEOUT_CYCLES=16, tx_done withheld.
  -> timeout_err pulses 16 cycles after entering WAIT_DONE; no ack; after the IFG, the same requester (sole req) is re-granted.
